// File: rtl/nibble_sort_pkg.sv
// Shared types and sizing for the 4-element nibble sorter.
// Sorting is a bubble sort that runs at most MAX_PASS passes.
package nibble_sort_pkg;

    localparam int unsigned N_ELEM   = 4;
    localparam int unsigned ELEM_W   = 4;
    localparam int unsigned MAX_PASS = 3;
    localparam int unsigned IDX_W    = 2;
    localparam int unsigned CNT_W    = 3;
    localparam int unsigned MAX_SWAP = 6;

    typedef enum logic [1:0] {
        StLoad  = 2'd0,
        StSort  = 2'd1,
        StDrain = 2'd2
    } state_e;

endpackage

// File: rtl/nibble_sort_ctrl_if.sv
// Load/drain stream handshake plus status for the nibble sorter.
// The master side is the producer/consumer; the slave side is the sorter.
interface nibble_sort_ctrl_if;
    import nibble_sort_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [ELEM_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [ELEM_W-1:0] out_data;
    logic              busy;
    logic [CNT_W-1:0]  swap_cnt;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy, swap_cnt
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, busy, swap_cnt
    );

endinterface

// File: rtl/nibble_cmp.sv
// Unsigned magnitude comparator for two nibbles; exactly one output is high.
module nibble_cmp
    import nibble_sort_pkg::*;
(
    input  logic [ELEM_W-1:0] a,
    input  logic [ELEM_W-1:0] b,
    output logic              a_gt_b,
    output logic              a_eq_b,
    output logic              a_ls_b
);

    assign a_gt_b = (a > b);
    assign a_eq_b = (a == b);
    assign a_ls_b = (a < b);

endmodule

// File: rtl/nibble_sort_ctrl.sv
// Loads a 4-nibble frame, bubble-sorts it one compare per cycle, then streams it out.
// A pass with no swaps ends sorting early; otherwise at most MAX_PASS passes run.
module nibble_sort_ctrl
    import nibble_sort_pkg::*;
#(
    parameter bit DESC = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    nibble_sort_ctrl_if.slave  bus
);

    state_e             state_q;
    logic [ELEM_W-1:0]  elem_q [N_ELEM];
    logic [IDX_W-1:0]   ld_idx_q;
    logic [IDX_W-1:0]   out_idx_q;
    logic [IDX_W-1:0]   idx_q;
    logic [IDX_W-1:0]   pass_q;
    logic               pass_swap_q;
    logic [CNT_W-1:0]   swap_cnt_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic               busy_q;

    logic [IDX_W-1:0]   idx_nxt;
    logic [ELEM_W-1:0]  cmp_a;
    logic [ELEM_W-1:0]  cmp_b;
    logic               a_gt_b;
    logic               a_eq_b;
    logic               a_ls_b;
    logic               do_swap;

    assign idx_nxt = idx_q + 2'd1;
    assign cmp_a   = elem_q[idx_q];
    assign cmp_b   = elem_q[idx_nxt];

    nibble_cmp u_cmp (
        .a      (cmp_a),
        .b      (cmp_b),
        .a_gt_b (a_gt_b),
        .a_eq_b (a_eq_b),
        .a_ls_b (a_ls_b)
    );

    // Equal pairs never satisfy either condition, which keeps the sort stable.
    assign do_swap = DESC ? a_ls_b : a_gt_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StLoad;
            for (int i = 0; i < N_ELEM; i++) elem_q[i] <= '0;
            ld_idx_q    <= '0;
            out_idx_q   <= '0;
            idx_q       <= '0;
            pass_q      <= '0;
            pass_swap_q <= 1'b0;
            swap_cnt_q  <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state_q)
                StLoad: begin
                    if (bus.in_valid) begin
                        elem_q[ld_idx_q] <= bus.in_data;
                        ld_idx_q         <= ld_idx_q + 2'd1;
                        if (ld_idx_q == IDX_W'(N_ELEM - 1)) begin
                            state_q    <= StSort;
                            in_ready_q <= 1'b0;
                            busy_q     <= 1'b1;
                        end
                    end
                end
                StSort: begin
                    if (do_swap) begin
                        elem_q[idx_q]   <= cmp_b;
                        elem_q[idx_nxt] <= cmp_a;
                        if (swap_cnt_q != CNT_W'(MAX_SWAP)) swap_cnt_q <= swap_cnt_q + 3'd1;
                    end
                    pass_swap_q <= pass_swap_q | do_swap;
                    if (idx_q == IDX_W'(N_ELEM - 2)) begin
                        if (!(pass_swap_q || do_swap) || pass_q == IDX_W'(MAX_PASS - 1)) begin
                            state_q     <= StDrain;
                            out_valid_q <= 1'b1;
                        end else begin
                            pass_q      <= pass_q + 2'd1;
                            idx_q       <= '0;
                            pass_swap_q <= 1'b0;
                        end
                    end else begin
                        idx_q <= idx_nxt;
                    end
                end
                StDrain: begin
                    if (bus.out_ready) begin
                        if (out_idx_q == IDX_W'(N_ELEM - 1)) begin
                            state_q     <= StLoad;
                            ld_idx_q    <= '0;
                            out_idx_q   <= '0;
                            idx_q       <= '0;
                            pass_q      <= '0;
                            pass_swap_q <= 1'b0;
                            swap_cnt_q  <= '0;
                            in_ready_q  <= 1'b1;
                            out_valid_q <= 1'b0;
                            busy_q      <= 1'b0;
                        end else begin
                            out_idx_q <= out_idx_q + 2'd1;
                        end
                    end
                end
                default: state_q <= StLoad;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = elem_q[out_idx_q];
    assign bus.busy      = busy_q;
    assign bus.swap_cnt  = swap_cnt_q;

endmodule

// File: tb/tb_nibble_sort_ctrl.sv
// Directed bench for nibble_sort_ctrl: ascending and descending instances share stimulus,
// and the one under test is chosen with sel.
module tb_nibble_sort_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [3:0] in_data;
    logic       out_ready;
    logic       sel;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    nibble_sort_ctrl_if bus0 ();
    nibble_sort_ctrl_if bus1 ();

    assign bus0.in_valid  = in_valid;
    assign bus0.in_data   = in_data;
    assign bus0.out_ready = out_ready;
    assign bus1.in_valid  = in_valid;
    assign bus1.in_data   = in_data;
    assign bus1.out_ready = out_ready;

    nibble_sort_ctrl #(.DESC(1'b0)) u_dut_asc (.clk(clk), .rst(rst), .bus(bus0.slave));
    nibble_sort_ctrl #(.DESC(1'b1)) u_dut_desc (.clk(clk), .rst(rst), .bus(bus1.slave));

    logic       in_ready_w;
    logic       out_valid_w;
    logic       busy_w;
    logic [3:0] out_data_w;
    logic [2:0] swap_cnt_w;

    assign in_ready_w  = sel ? bus1.in_ready  : bus0.in_ready;
    assign out_valid_w = sel ? bus1.out_valid : bus0.out_valid;
    assign busy_w      = sel ? bus1.busy      : bus0.busy;
    assign out_data_w  = sel ? bus1.out_data  : bus0.out_data;
    assign swap_cnt_w  = sel ? bus1.swap_cnt  : bus0.swap_cnt;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_in_ready"},  32'(in_ready_w),  32'd1);
        check({tag, "_out_valid"}, 32'(out_valid_w), 32'd0);
        check({tag, "_busy"},      32'(busy_w),      32'd0);
        check({tag, "_swap_cnt"},  32'(swap_cnt_w),  32'd0);
    endtask

    // Element i of a frame is d[15-4*i -: 4], so 16'h1234 loads 1,2,3,4.
    task automatic load_frame(input logic [15:0] d, input bit hold, input logic [3:0] next);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = d[15-4*i -: 4];
            check("in_ready_load", 32'(in_ready_w), 32'd1);
            step();
        end
        if (hold) in_data = next;
        else      in_valid = 1'b0;
        check("busy_sort", 32'(busy_w), 32'd1);
        check("in_ready_sort", 32'(in_ready_w), 32'd0);
    endtask

    task automatic wait_sort(input int exp_cyc);
        int cyc = 0;
        while (!out_valid_w && cyc < 50) begin
            step();
            cyc++;
        end
        check("sort_cycles", 32'(cyc), 32'(exp_cyc));
    endtask

    task automatic drain(input logic [15:0] exp, input logic [2:0] exp_swaps, input bit stall);
        for (int k = 0; k < 4; k++) begin
            if (stall) begin
                out_ready = 1'b0;
                step();
                check("stall_valid", 32'(out_valid_w), 32'd1);
                check("stall_data", 32'(out_data_w), 32'(exp[15-4*k -: 4]));
            end
            out_ready = 1'b1;
            check("out_data", 32'(out_data_w), 32'(exp[15-4*k -: 4]));
            check("swap_hold", 32'(swap_cnt_w), 32'(exp_swaps));
            check("in_ready_drain", 32'(in_ready_w), 32'd0);
            step();
        end
        out_ready = 1'b0;
        check_idle("after_drain");
    endtask

    task automatic run_frame(input logic [15:0] d, input logic [15:0] exp, input int cyc,
                             input logic [2:0] swaps, input bit stall, input bit hold,
                             input logic [3:0] next);
        load_frame(d, hold, next);
        wait_sort(cyc);
        drain(exp, swaps, stall);
    endtask

    initial begin
        sel       = 1'b0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 4'h0;
        out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        check_idle("reset");
        check("reset_out_data", 32'(out_data_w), 32'd0);

        run_frame(16'h1234, 16'h1234, 3, 3'd0, 1'b0, 1'b0, 4'h0);
        run_frame(16'h9630, 16'h0369, 9, 3'd6, 1'b0, 1'b0, 4'h0);
        run_frame(16'hF0F0, 16'h00FF, 9, 3'd3, 1'b0, 1'b0, 4'h0);
        run_frame(16'h5A27, 16'h257A, 9, 3'd3, 1'b1, 1'b0, 4'h0);

        // Reset during the second SORT cycle.
        load_frame(16'h9630, 1'b0, 4'h0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_idle("rst_sort");
        run_frame(16'h3130, 16'h0133, 9, 3'd4, 1'b0, 1'b0, 4'h0);

        // Reset during DRAIN after two transfers.
        load_frame(16'h2817, 1'b0, 4'h0);
        wait_sort(9);
        out_ready = 1'b1;
        step();
        step();
        check("drain_idx2_data", 32'(out_data_w), 32'h7);
        out_ready = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_idle("rst_drain");
        run_frame(16'h1234, 16'h1234, 3, 3'd0, 1'b0, 1'b0, 4'h0);

        // Back-to-back frames with in_valid held high throughout.
        run_frame(16'hC4E1, 16'h14CE, 9, 3'd4, 1'b0, 1'b1, 4'hB);
        run_frame(16'hB2D8, 16'h28BD, 9, 3'd3, 1'b0, 1'b0, 4'h0);

        // Descending instance.
        sel = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_idle("desc_reset");
        run_frame(16'hF0F0, 16'hFF00, 6, 3'd1, 1'b0, 1'b0, 4'h0);
        run_frame(16'h0369, 16'h9630, 9, 3'd6, 1'b1, 1'b0, 4'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/nibble_sort_ctrl.md
NIBBLE_SORT_CTRL -- requirements
Module: nibble_sort_ctrl

Interface
REQ-001 SHALL have parameter DESC, default 0, sort order (0 = ascending, 1 = descending).
REQ-002 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  in_data holds a valid element.
REQ-005 SHALL have port in_ready  output  1  block accepts an element this cycle.
REQ-006 SHALL have port in_data  input  4  unsigned element to load.
REQ-007 SHALL have port out_valid  output  1  out_data holds a valid sorted element.
REQ-008 SHALL have port out_ready  input  1  consumer accepts out_data this cycle.
REQ-009 SHALL have port out_data  output  4  sorted element, index 0 first.
REQ-010 SHALL have port busy  output  1  high in SORT and DRAIN.
REQ-011 SHALL have port swap_cnt  output  3  swaps performed on the current frame, 0..6.

Function
REQ-012 SHALL implement FSM states LOAD, SORT and DRAIN; frame = 4 elements held in registers e0..e3.
REQ-013 LOAD: in_ready = 1; on in_valid&&in_ready, SHALL store in_data to e[ld_idx] and increment ld_idx (0..3).
REQ-014 The 4th accept SHALL move the FSM to SORT on the next edge; in_ready SHALL be 0 outside LOAD.
REQ-015 SORT: one comparison per cycle on the pair (e[idx], e[idx+1]), idx = 0,1,2; a pass = 3 cycles.
REQ-016 Swap condition SHALL be A_gt_B (DESC = 0) or A_ls_B (DESC = 1); equal elements SHALL never swap (stable).
REQ-017 On a swap, SHALL exchange the pair in the same edge and increment swap_cnt (saturates at 6; it cannot exceed 6).
REQ-018 At idx = 2, SHALL go to DRAIN if the pass had no swaps (including this cycle) or pass = 2; otherwise pass++, idx = 0.
REQ-019 SORT latency SHALL be 3 cycles (input already sorted) to 9 cycles (worst case).
REQ-020 DRAIN: out_valid = 1, out_data = e[out_idx]; on out_valid&&out_ready, out_idx++.
REQ-021 out_data SHALL stay stable while out_valid && !out_ready.
REQ-022 The 4th DRAIN transfer SHALL return the FSM to LOAD and clear ld_idx, out_idx, pass, idx and swap_cnt.
REQ-023 swap_cnt SHALL hold its final value throughout DRAIN.
REQ-024 in_valid SHALL be ignored outside LOAD; out_ready SHALL be ignored outside DRAIN.
REQ-025 No element SHALL be accepted in the cycle of the DRAIN-to-LOAD transition; the first accept is possible one cycle later.

Reset
REQ-026 rst SHALL take priority over all other inputs in any state, including mid-SORT and mid-DRAIN.
REQ-027 rst SHALL force state LOAD; e0..e3, ld_idx, out_idx, pass, idx and swap_cnt = 0.
REQ-028 Outputs after reset SHALL be in_ready = 1, out_valid = 0, out_data = 0, busy = 0, swap_cnt = 0.
REQ-029 Any partially loaded or partially drained frame SHALL be discarded on rst.

Structure
REQ-030 Shared package nibble_sort_pkg SHALL hold the state encoding, N_ELEM = 4, ELEM_W = 4 and MAX_PASS = 3.
REQ-031 The single comparator SHALL be a sub-module nibble_cmp.
  - Inputs: 4-bit A and B.
  - Outputs: one-hot A_gt_B, A_eq_B, A_ls_B.
  - Purely combinational, instantiated once.
  - The FSM muxes the selected pair into it.
REQ-032 Expected RTL size is 120-400 lines including nibble_cmp.

Verification
REQ-033 Sorted input: load 1,2,3,4 (DESC = 0) -> SORT 3 cycles, swap_cnt = 0, outputs 1,2,3,4.
REQ-034 Reversed input: load 9,6,3,0 (DESC = 0) -> SORT 9 cycles, swap_cnt = 6, outputs 0,3,6,9.
REQ-035 Ties and extremes: load F,0,F,0 (DESC = 0) -> outputs 0,0,F,F, swap_cnt = 3; same data with DESC = 1 -> F,F,0,0, swap_cnt = 1.
REQ-036 Backpressure: frame 5,A,2,7 with out_ready toggling 0/1 -> out_data stable while stalled, order 2,5,7,A, in_ready = 0 until the 4th transfer +1 cycle.
REQ-037 Reset mid-operation: assert rst during the 2nd SORT cycle, then during DRAIN with out_idx = 2 -> next cycle LOAD, in_ready = 1, out_valid = 0, swap_cnt = 0; a fresh frame sorts correctly.
REQ-038 Back-to-back: two frames with in_valid held high -> no element lost or duplicated; the second frame starts loading one cycle after the first drains.
